// File: rtl/pic_pkg.sv
// rtl/pic_pkg.sv - shared state encoding and ICW bit positions for the 8259 init path
package pic_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } icw_state_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;

    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;
    localparam int ICW4_SFNM = 4;

endpackage

// File: rtl/pic_strobe_commit.sv
// rtl/pic_strobe_commit.sv - registers a write strobe, captures the bus while high, flags the falling edge
module pic_strobe_commit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       strobe,
    input  logic [7:0] bus,
    output logic       commit,
    output logic [7:0] data
);

    logic       s_q;
    logic       blocked;
    logic [7:0] hold;

    // A strobe already high while reset is asserted stays blocked until it drops,
    // so releasing reset mid-pulse never produces a commit.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q     <= 1'b0;
            hold    <= 8'h00;
            blocked <= strobe;
        end else begin
            if (!strobe) begin
                blocked <= 1'b0;
            end
            s_q <= strobe & ~blocked;
            if (strobe && !blocked) begin
                hold <= bus;
            end
        end
    end

    assign commit = s_q & ~strobe;
    assign data   = hold;

endmodule

// File: rtl/icw_init_sequencer.sv
// rtl/icw_init_sequencer.sv - 8259 ICW1..ICW4 initialisation sequencer and configuration registers
module icw_init_sequencer
    import pic_pkg::*;
#(
    parameter logic [4:0] VEC_BASE_RST = 5'd0,
    parameter logic [7:0] CASCADE_RST  = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       write_ICW_1,
    input  logic       write_ICW2_4,
    input  logic [7:0] internal_bus,
    output logic       init_busy,
    output logic       init_done,
    output logic       icw1_pulse,
    output logic       level_trigger,
    output logic       single_mode,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_cfg,
    output logic       upm,
    output logic       aeoi,
    output logic       buf_master,
    output logic       buffered,
    output logic       sfnm
);

    logic       c1_commit;
    logic [7:0] c1_data;
    logic       c24_commit;
    logic [7:0] c24_data;
    logic       ic4;
    icw_state_t state;

    pic_strobe_commit u_icw1_commit (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (write_ICW_1),
        .bus    (internal_bus),
        .commit (c1_commit),
        .data   (c1_data)
    );

    pic_strobe_commit u_icw24_commit (
        .clk    (clk),
        .rst_n  (rst_n),
        .strobe (write_ICW2_4),
        .bus    (internal_bus),
        .commit (c24_commit),
        .data   (c24_data)
    );

    logic unused_icw1_bits;
    assign unused_icw1_bits = ^{c1_data[7:4], c1_data[2]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_UNINIT;
            ic4           <= 1'b0;
            level_trigger <= 1'b0;
            single_mode   <= 1'b0;
            vector_base   <= VEC_BASE_RST;
            cascade_cfg   <= CASCADE_RST;
            upm           <= 1'b0;
            aeoi          <= 1'b0;
            buf_master    <= 1'b0;
            buffered      <= 1'b0;
            sfnm          <= 1'b0;
            icw1_pulse    <= 1'b0;
            init_done     <= 1'b0;
        end else begin
            icw1_pulse <= 1'b0;
            // ICW1 restarts from any state and shadows a coincident ICW2_4 commit.
            if (c1_commit) begin
                level_trigger <= c1_data[ICW1_LTIM];
                single_mode   <= c1_data[ICW1_SNGL];
                ic4           <= c1_data[ICW1_IC4];
                upm           <= 1'b0;
                aeoi          <= 1'b0;
                buf_master    <= 1'b0;
                buffered      <= 1'b0;
                sfnm          <= 1'b0;
                icw1_pulse    <= 1'b1;
                init_done     <= 1'b0;
                state         <= ST_WAIT_ICW2;
            end else if (c24_commit) begin
                case (state)
                    ST_WAIT_ICW2: begin
                        vector_base <= c24_data[7:3];
                        if (!single_mode) begin
                            state <= ST_WAIT_ICW3;
                        end else if (ic4) begin
                            state <= ST_WAIT_ICW4;
                        end else begin
                            state     <= ST_READY;
                            init_done <= 1'b1;
                        end
                    end
                    ST_WAIT_ICW3: begin
                        cascade_cfg <= c24_data;
                        if (ic4) begin
                            state <= ST_WAIT_ICW4;
                        end else begin
                            state     <= ST_READY;
                            init_done <= 1'b1;
                        end
                    end
                    ST_WAIT_ICW4: begin
                        upm        <= c24_data[ICW4_UPM];
                        aeoi       <= c24_data[ICW4_AEOI];
                        buf_master <= c24_data[ICW4_MS];
                        buffered   <= c24_data[ICW4_BUF];
                        sfnm       <= c24_data[ICW4_SFNM];
                        state      <= ST_READY;
                        init_done  <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign init_busy = (state == ST_WAIT_ICW2) || (state == ST_WAIT_ICW3) || (state == ST_WAIT_ICW4);

endmodule

// File: tb/tb_icw_init_sequencer.sv
// tb/tb_icw_init_sequencer.sv - self-checking bench for icw_init_sequencer
module tb_icw_init_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       write_ICW_1 = 1'b0;
    logic       write_ICW2_4 = 1'b0;
    logic [7:0] internal_bus = 8'h00;
    logic       init_busy, init_done, icw1_pulse, level_trigger, single_mode;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic       upm, aeoi, buf_master, buffered, sfnm;

    icw_init_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .write_ICW_1   (write_ICW_1),
        .write_ICW2_4  (write_ICW2_4),
        .internal_bus  (internal_bus),
        .init_busy     (init_busy),
        .init_done     (init_done),
        .icw1_pulse    (icw1_pulse),
        .level_trigger (level_trigger),
        .single_mode   (single_mode),
        .vector_base   (vector_base),
        .cascade_cfg   (cascade_cfg),
        .upm           (upm),
        .aeoi          (aeoi),
        .buf_master    (buf_master),
        .buffered      (buffered),
        .sfnm          (sfnm)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int pulse_cnt = 0;

    always @(negedge clk) if (icw1_pulse === 1'b1) pulse_cnt++;

    // Reference model: an ICW1 sets up the list of ICWs still owed; each A1=1 write consumes one.
    int         m_q[$];
    logic       m_ltim, m_sngl, m_done;
    logic [4:0] m_vb, m_icw4;
    logic [7:0] m_casc;

    function automatic void model_reset();
        m_q.delete();
        m_ltim = 0; m_sngl = 0; m_done = 0;
        m_vb = 5'd0; m_icw4 = 5'd0; m_casc = 8'h00;
    endfunction

    function automatic void model_icw1(input logic [7:0] d);
        m_ltim = d[3];
        m_sngl = d[1];
        m_icw4 = 5'd0;
        m_done = 0;
        m_q.delete();
        m_q.push_back(2);
        if (!d[1]) m_q.push_back(3);
        if (d[0])  m_q.push_back(4);
    endfunction

    function automatic void model_icw24(input logic [7:0] d);
        int k;
        if (m_q.size() == 0) return;
        k = m_q.pop_front();
        if (k == 2) m_vb = d[7:3];
        else if (k == 3) m_casc = d;
        else m_icw4 = d[4:0];
        if (m_q.size() == 0) m_done = 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] icw4_out();
        return {sfnm, buffered, buf_master, aeoi, upm};
    endfunction

    // One write pulse; the bus only carries the intended byte in the last high cycle.
    task automatic do_write(input bit is1, input logic [7:0] d, input int hi);
        for (int i = 0; i < hi; i++) begin
            if (is1) write_ICW_1 = 1'b1; else write_ICW2_4 = 1'b1;
            internal_bus = (i == hi - 1) ? d : 8'($urandom);
            step();
        end
        write_ICW_1 = 1'b0;
        write_ICW2_4 = 1'b0;
        internal_bus = 8'($urandom);
        step();
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".busy"}, 32'(init_busy), 32'(m_q.size() != 0));
        chk({tag, ".done"}, 32'(init_done), 32'(m_done));
        chk({tag, ".ltim"}, 32'(level_trigger), 32'(m_ltim));
        chk({tag, ".sngl"}, 32'(single_mode), 32'(m_sngl));
        chk({tag, ".vb"}, 32'(vector_base), 32'(m_vb));
        chk({tag, ".casc"}, 32'(cascade_cfg), 32'(m_casc));
        chk({tag, ".icw4"}, 32'(icw4_out()), 32'(m_icw4));
    endtask

    task automatic do_reset();
        write_ICW_1 = 1'b0;
        write_ICW2_4 = 1'b0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    typedef struct {
        bit         is1;
        logic [7:0] d;
        logic       busy, done, ltim, sngl;
        logic [4:0] vb;
        logic [7:0] casc;
        logic [4:0] icw4;
    } vec_t;

    vec_t tbl[12];

    initial begin
        int base;
        tbl[0]  = '{1'b1, 8'h13, 1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 8'h00, 5'h00};
        tbl[1]  = '{1'b0, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 5'd2, 8'h00, 5'h00};
        tbl[2]  = '{1'b0, 8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 5'd2, 8'h00, 5'h01};
        tbl[3]  = '{1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 5'd2, 8'h00, 5'h00};
        tbl[4]  = '{1'b0, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'h00, 5'h00};
        tbl[5]  = '{1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 8'h04, 5'h00};
        tbl[6]  = '{1'b0, 8'h1F, 1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 8'h04, 5'h1F};
        tbl[7]  = '{1'b1, 8'h12, 1'b1, 1'b0, 1'b0, 1'b1, 5'd1, 8'h04, 5'h00};
        tbl[8]  = '{1'b0, 8'h20, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 8'h04, 5'h00};
        tbl[9]  = '{1'b0, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 5'd4, 8'h04, 5'h00};
        tbl[10] = '{1'b1, 8'h1A, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 8'h04, 5'h00};
        tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 5'd0, 8'h04, 5'h00};

        do_reset();
        step();
        chk("rst.busy", 32'(init_busy), 0);
        chk("rst.done", 32'(init_done), 0);
        chk("rst.pulse", 32'(icw1_pulse), 0);
        chk("rst.vb", 32'(vector_base), 0);
        chk("rst.casc", 32'(cascade_cfg), 0);
        chk("rst.cfg", 32'({level_trigger, single_mode, icw4_out()}), 0);

        // Scenarios 1-3 plus an OCW1 in READY and an LTIM=1 ICW1.
        for (int i = 0; i < 12; i++) begin
            do_write(tbl[i].is1, tbl[i].d, 1 + (i % 3));
            chk($sformatf("tbl%0d.pulse", i), 32'(icw1_pulse), 32'(tbl[i].is1));
            chk($sformatf("tbl%0d.busy", i), 32'(init_busy), 32'(tbl[i].busy));
            chk($sformatf("tbl%0d.done", i), 32'(init_done), 32'(tbl[i].done));
            chk($sformatf("tbl%0d.ltim", i), 32'(level_trigger), 32'(tbl[i].ltim));
            chk($sformatf("tbl%0d.sngl", i), 32'(single_mode), 32'(tbl[i].sngl));
            chk($sformatf("tbl%0d.vb", i), 32'(vector_base), 32'(tbl[i].vb));
            chk($sformatf("tbl%0d.casc", i), 32'(cascade_cfg), 32'(tbl[i].casc));
            chk($sformatf("tbl%0d.icw4", i), 32'(icw4_out()), 32'(tbl[i].icw4));
            step();
            chk($sformatf("tbl%0d.pulse_end", i), 32'(icw1_pulse), 0);
        end

        // Long ICW1 strobe: exactly one pulse, one cycle after the fall.
        base = pulse_cnt;
        write_ICW_1 = 1'b1;
        internal_bus = 8'h13;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("long.no_pulse_high", 32'(icw1_pulse), 0);
        end
        write_ICW_1 = 1'b0;
        step();
        chk("long.pulse", 32'(icw1_pulse), 1);
        step();
        chk("long.pulse_off", 32'(icw1_pulse), 0);
        chk("long.count", 32'(pulse_cnt - base), 1);
        chk("long.busy", 32'(init_busy), 1);

        // Two ICW2_4 pulses separated by one low cycle give two commits.
        write_ICW2_4 = 1'b1; internal_bus = 8'h10; step();
        write_ICW2_4 = 1'b0; step();
        write_ICW2_4 = 1'b1; internal_bus = 8'h1F; step();
        write_ICW2_4 = 1'b0; step();
        chk("b2b.done", 32'(init_done), 1);
        chk("b2b.vb", 32'(vector_base), 2);
        chk("b2b.icw4", 32'(icw4_out()), 32'h1F);

        // Coincident commits: ICW1 wins, the ICW2 is dropped.
        do_write(1'b1, 8'h11, 1);
        write_ICW_1 = 1'b1; write_ICW2_4 = 1'b1; internal_bus = 8'h13; step();
        write_ICW_1 = 1'b0; write_ICW2_4 = 1'b0; step();
        chk("both.pulse", 32'(icw1_pulse), 1);
        chk("both.busy", 32'(init_busy), 1);
        chk("both.sngl", 32'(single_mode), 1);
        chk("both.vb", 32'(vector_base), 2);

        // Restart mid-sequence (cascade), then ICW2 lands in the restarted sequence.
        do_write(1'b1, 8'h11, 2);
        do_write(1'b0, 8'h08, 2);
        base = pulse_cnt;
        do_write(1'b1, 8'h11, 1);
        chk("restart.pulse", 32'(icw1_pulse), 1);
        chk("restart.busy", 32'(init_busy), 1);
        chk("restart.done", 32'(init_done), 0);
        do_write(1'b0, 8'h28, 1);
        chk("restart.vb", 32'(vector_base), 5);
        chk("restart.busy2", 32'(init_busy), 1);
        chk("restart.done2", 32'(init_done), 0);
        chk("restart.count", 32'(pulse_cnt - base), 1);

        // Reset during WAIT_ICW3 with the A1=1 strobe held across release.
        do_write(1'b1, 8'h19, 1);
        do_write(1'b0, 8'hF8, 1);
        chk("rst3.pre_vb", 32'(vector_base), 31);
        write_ICW2_4 = 1'b1; internal_bus = 8'hAA; step();
        rst_n = 1'b0; step(); step();
        rst_n = 1'b1; step(); step();
        write_ICW2_4 = 1'b0; step();
        chk("rst3.busy", 32'(init_busy), 0);
        chk("rst3.done", 32'(init_done), 0);
        chk("rst3.vb", 32'(vector_base), 0);
        chk("rst3.casc", 32'(cascade_cfg), 0);
        chk("rst3.cfg", 32'({level_trigger, single_mode, icw4_out(), icw1_pulse}), 0);
        do_write(1'b0, 8'h55, 1);
        chk("rst3.ocw_vb", 32'(vector_base), 0);
        chk("rst3.ocw_casc", 32'(cascade_cfg), 0);
        chk("rst3.ocw_busy", 32'(init_busy), 0);
        chk("rst3.ocw_done", 32'(init_done), 0);

        // Randomised writes against the queue-based model.
        do_reset();
        model_reset();
        for (int n = 0; n < 250; n++) begin
            bit         is1;
            logic [7:0] d;
            is1 = ($urandom_range(0, 3) == 0);
            d = 8'($urandom);
            do_write(is1, d, $urandom_range(1, 4));
            if (is1) model_icw1(d); else model_icw24(d);
            chk($sformatf("rnd%0d.pulse", n), 32'(icw1_pulse), 32'(is1));
            check_model($sformatf("rnd%0d", n));
            for (int g = $urandom_range(0, 2); g > 0; g--) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
